red_pitaya_pwm_dac: RTL and testbench



---
 rtl/red_pitaya_pwm_dac_pkg.sv | 25 ++
 rtl/red_pitaya_pwm_dac.sv | 64 ++++++
 tb/tb_red_pitaya_pwm_dac.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/red_pitaya_pwm_dac_pkg.sv
// Shared constants for the PWM DAC: default period length and the layout of the 24-bit setting word.
package red_pitaya_pwm_dac_pkg;

  localparam int unsigned PWM_FULL_DEF = 156;

  localparam int unsigned PWM_V_W   = 8;
  localparam int unsigned PWM_B_W   = 16;
  localparam int unsigned PWM_CFG_W = PWM_V_W + PWM_B_W;

  localparam int unsigned PWM_CFG_V_MSB = PWM_CFG_W - 1;
  localparam int unsigned PWM_CFG_V_LSB = PWM_B_W;
  localparam int unsigned PWM_CFG_B_MSB = PWM_B_W - 1;
  localparam int unsigned PWM_CFG_B_LSB = 0;

  localparam int unsigned PWM_SUPER_N = 16;

  function automatic logic [PWM_V_W-1:0] cfg_duty(input logic [PWM_CFG_W-1:0] cfg);
    return cfg[PWM_CFG_V_MSB:PWM_CFG_V_LSB];
  endfunction

  function automatic logic [PWM_B_W-1:0] cfg_dither(input logic [PWM_CFG_W-1:0] cfg);
    return cfg[PWM_CFG_B_MSB:PWM_CFG_B_LSB];
  endfunction

endpackage

// File: rtl/red_pitaya_pwm_dac.sv
// Single-bit PWM DAC with 16-period dithered super-cycle; settings load only at super-cycle boundaries.
// Outputs registered, one cycle behind the counters; no backpressure, free-running.
module red_pitaya_pwm_dac
  import red_pitaya_pwm_dac_pkg::*;
#(
  parameter int unsigned FULL = PWM_FULL_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PWM_CFG_W-1:0] cfg_i,
  output logic                 pwm_o,
  output logic                 sync_o
);

  if (FULL < 2 || FULL > 255) begin : g_full_range
    $error("FULL must be within 2..255");
  end

  localparam logic [PWM_V_W-1:0] LAST = PWM_V_W'(FULL - 1);

  logic [PWM_V_W-1:0] vcnt;
  logic [3:0]         bcnt;
  logic [PWM_V_W-1:0] v_r;
  logic [PWM_B_W-1:0] b_r;

  logic               per_end;
  logic               super_end;
  logic [PWM_V_W:0]   duty_lim;
  logic               high;

  assign per_end   = (vcnt == LAST);
  assign super_end = per_end && (bcnt == 4'hF);

  // 9-bit compare so v_r = 255 plus a dither bit does not wrap to 0.
  assign duty_lim = {1'b0, v_r} + {{PWM_V_W{1'b0}}, b_r[0]};
  assign high     = {1'b0, vcnt} < duty_lim;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vcnt   <= LAST;
      bcnt   <= 4'hF;
      v_r    <= '0;
      b_r    <= '0;
      pwm_o  <= 1'b0;
      sync_o <= 1'b0;
    end else begin
      pwm_o  <= high;
      sync_o <= super_end;
      if (per_end) begin
        vcnt <= '0;
        bcnt <= bcnt + 4'd1;
        if (super_end) begin
          v_r <= cfg_duty(cfg_i);
          b_r <= cfg_dither(cfg_i);
        end else begin
          b_r <= {b_r[0], b_r[PWM_B_W-1:1]};
        end
      end else begin
        vcnt <= vcnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_pwm_dac.sv
// Randomized bench for red_pitaya_pwm_dac against a per-cycle arithmetic model of the dithered PWM stream.
module tb_red_pitaya_pwm_dac;
  import red_pitaya_pwm_dac_pkg::*;

  localparam int F  = PWM_FULL_DEF;
  localparam int SC = 16 * F;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [23:0] cfg_i;
  logic        pwm_o;
  logic        sync_o;

  int tests = 0;
  int fails = 0;

  int          n;
  int          hi_cnt;
  bit          exp_pwm;
  bit          lit_chk;
  logic [23:0] act_cfg;
  logic [23:0] pend_cfg;
  logic [23:0] plan [0:12];
  int          lit_tot [0:5] = '{240, 1249, 2496, 2496, 0, 1880};

  always #5 clk_i = ~clk_i;

  red_pitaya_pwm_dac #(.FULL(F)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cfg_i  (cfg_i),
    .pwm_o  (pwm_o),
    .sync_o (sync_o)
  );

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, n);
    end
  endtask

  // High cycles in period k: min(v + b[k], FULL).
  function automatic int period_high(input logic [23:0] c, input int k);
    int lim;
    logic [15:0] b;
    b   = c[15:0];
    lim = int'(c[23:16]) + int'(b[k]);
    return (lim > F) ? F : lim;
  endfunction

  function automatic int super_total(input logic [23:0] c);
    int t = 0;
    for (int k = 0; k < 16; k++) t += period_high(c, k);
    return t;
  endfunction

  // State at cycle idx (relative to the sync cycle) is period (idx%SC)/F, position idx%F.
  function automatic bit model_high(input int idx, input logic [23:0] c);
    return (idx % F) < period_high(c, (idx % SC) / F);
  endfunction

  task automatic release_reset();
    rst_i    = 1'b0;
    pend_cfg = cfg_i;
    n        = 0;
    exp_pwm  = 1'b0;
    hi_cnt   = 0;
  endtask

  task automatic step();
    int pos;
    int sidx;
    int upd_pos;
    @(negedge clk_i);
    chk("sync_o", int'(sync_o), int'(n % SC == 0));
    chk("pwm_o", int'(pwm_o), int'(exp_pwm));
    if (n > 0) hi_cnt += int'(pwm_o);
    if (n % SC == 0) begin
      if (n > 0) begin
        chk("super_total", hi_cnt, super_total(act_cfg));
        if (lit_chk && (n / SC - 1) < 6) chk("super_total_lit", hi_cnt, lit_tot[n / SC - 1]);
      end
      hi_cnt  = 0;
      act_cfg = pend_cfg;
    end
    exp_pwm = model_high(n, act_cfg);

    pos     = n % SC;
    sidx    = n / SC;
    upd_pos = (sidx % 2 == 0) ? 1000 : SC - 1;
    if (pos == 500) cfg_i = 24'($urandom);
    if (pos == upd_pos) cfg_i = plan[(sidx + 1 > 12) ? 12 : sidx + 1];
    if (pos == SC - 1) pend_cfg = cfg_i;
    n++;
  endtask

  initial begin
    n       = 0;
    lit_chk = 1'b0;
    plan[0] = 24'h0F_0000;
    plan[1] = 24'h4E_0001;
    plan[2] = 24'h9C_0000;
    plan[3] = 24'hFF_FFFF;
    plan[4] = 24'h00_0000;
    plan[5] = 24'h75_AAAA;
    for (int i = 6; i < 12; i++) plan[i] = 24'($urandom);
    plan[7][23:16] = 8'(F - 1);
    plan[8][23:16] = 8'(F);
    plan[12] = 24'h80_1234;

    rst_i = 1'b1;
    cfg_i = plan[0];
    repeat (3) @(negedge clk_i);
    chk("reset_pwm", int'(pwm_o), 0);
    chk("reset_sync", int'(sync_o), 0);

    lit_chk = 1'b1;
    release_reset();
    repeat (12 * SC + 1) step();
    lit_chk = 1'b0;

    for (int i = 0; i < 50 && pwm_o !== 1'b1; i++) step();
    chk("pre_reset_pwm_high", int'(pwm_o), 1);

    rst_i = 1'b1;
    cfg_i = 24'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("midrst_pwm", int'(pwm_o), 0);
      chk("midrst_sync", int'(sync_o), 0);
      if (i == 1) cfg_i = {8'h3C, 16'($urandom)};
    end
    release_reset();
    repeat (SC + 1) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
